// File: rtl/ws_inst_sequencer.sv
// Weight-stationary tile instruction sequencer: emits the 34-bit core instruction word each cycle.
// Optional build macro SEQ_PERF_CNT_EN adds perf_cycles / stall_cycles counters.
module ws_inst_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int inst_bw = 34
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] len,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic               acc_en,
    input  logic               valid,
    output logic [inst_bw-1:0] inst,
    output logic               busy,
    output logic               done
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int CW     = addr_bw + 1;
    localparam int B_ACC  = 33;
    localparam int B_PCEN = 32;
    localparam int B_PWEN = 31;
    localparam int B_PA   = 20;
    localparam int B_XCEN = 19;
    localparam int B_XWEN = 18;
    localparam int B_XA   = 7;
    localparam int B_OFRD = 6;
    localparam int B_L0RD = 3;
    localparam int B_L0WR = 2;
    localparam int B_EXEC = 1;
    localparam int B_LOAD = 0;

    localparam logic [inst_bw-1:0] IDLE_W = (inst_bw'(1) << B_PCEN) | (inst_bw'(1) << B_PWEN)
                                          | (inst_bw'(1) << B_XCEN) | (inst_bw'(1) << B_XWEN);

    typedef enum logic [2:0] {
        S_IDLE, S_W_FETCH, S_W_LOAD, S_W_SETTLE, S_A_FETCH, S_A_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [CW-1:0]      r_rd_cnt, w_rd_cnt_nxt;
    logic [CW-1:0]      r_wr_cnt, w_wr_cnt_nxt;
    logic               r_pend, w_pend_nxt;
    logic               r_acc, w_acc_nxt;
    logic               w_rd, w_wr;
    logic [addr_bw-1:0] r_len, r_wb, r_ab, r_pb;
    logic [addr_bw-1:0] w_len_nxt, w_wb_nxt, w_ab_nxt, w_pb_nxt;
    logic [CW-1:0]      w_len_ext, w_len_nxt_ext;
    logic [inst_bw-1:0] r_inst, w_inst_nxt;
    logic               r_busy, r_done;

    assign w_len_ext     = {1'b0, r_len};
    assign w_len_nxt_ext = {1'b0, w_len_nxt};

    // Next-state and tile bookkeeping; the outgoing word is built from these next values
    // so every output register lines up with the state it describes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rd_cnt_nxt = r_rd_cnt;
        w_wr_cnt_nxt = r_wr_cnt;
        w_pend_nxt   = r_pend;
        w_acc_nxt    = r_acc;
        w_len_nxt    = r_len;
        w_wb_nxt     = r_wb;
        w_ab_nxt     = r_ab;
        w_pb_nxt     = r_pb;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_acc_nxt = 1'b0;
                if (start) begin
                    w_len_nxt   = len;
                    w_wb_nxt    = w_base;
                    w_ab_nxt    = a_base;
                    w_pb_nxt    = p_base;
                    w_acc_nxt   = acc_en;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (len == '0) ? S_DONE : S_W_FETCH;
                end
            end
            S_W_FETCH: begin
                if (r_cnt == CW'(row)) begin
                    w_state_nxt = S_W_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_W_LOAD: begin
                if (r_cnt == CW'(row + col - 1)) begin
                    w_state_nxt = S_W_SETTLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_W_SETTLE: begin
                if (r_cnt == CW'(row + col - 1)) begin
                    w_state_nxt = S_A_FETCH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_A_FETCH: begin
                if (r_cnt == w_len_ext) begin
                    w_state_nxt = S_A_EXEC;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_A_EXEC: begin
                if (r_cnt == w_len_ext - CW'(1)) begin
                    w_state_nxt  = S_DRAIN;
                    w_cnt_nxt    = '0;
                    w_rd_cnt_nxt = '0;
                    w_wr_cnt_nxt = '0;
                    w_pend_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                // A read issued this cycle turns into a psum write in the following cycle.
                if (r_wr_cnt == w_len_ext) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_rd         = valid && (r_rd_cnt < w_len_ext);
                    w_wr         = r_pend;
                    w_rd_cnt_nxt = r_rd_cnt + CW'(w_rd);
                    w_wr_cnt_nxt = r_wr_cnt + CW'(w_wr);
                    w_pend_nxt   = w_rd;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_acc_nxt   = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_inst_nxt = IDLE_W;
        if (w_state_nxt != S_IDLE && w_state_nxt != S_DONE)
            w_inst_nxt[B_ACC] = w_acc_nxt;
        case (w_state_nxt)
            S_W_FETCH: begin
                if (w_cnt_nxt < CW'(row)) begin
                    w_inst_nxt[B_XCEN]              = 1'b0;
                    w_inst_nxt[B_XA +: addr_bw]     = w_wb_nxt + w_cnt_nxt[addr_bw-1:0];
                end
                if (w_cnt_nxt != '0)
                    w_inst_nxt[B_L0WR] = 1'b1;
            end
            S_W_LOAD: begin
                w_inst_nxt[B_L0RD] = 1'b1;
                w_inst_nxt[B_LOAD] = 1'b1;
            end
            S_A_FETCH: begin
                if (w_cnt_nxt < w_len_nxt_ext) begin
                    w_inst_nxt[B_XCEN]              = 1'b0;
                    w_inst_nxt[B_XA +: addr_bw]     = w_ab_nxt + w_cnt_nxt[addr_bw-1:0];
                end
                if (w_cnt_nxt != '0)
                    w_inst_nxt[B_L0WR] = 1'b1;
            end
            S_A_EXEC: begin
                w_inst_nxt[B_L0RD] = 1'b1;
                w_inst_nxt[B_EXEC] = 1'b1;
            end
            S_DRAIN: begin
                w_inst_nxt[B_OFRD] = w_rd;
                if (w_wr) begin
                    w_inst_nxt[B_PCEN]          = 1'b0;
                    w_inst_nxt[B_PWEN]          = 1'b0;
                    w_inst_nxt[B_PA +: addr_bw] = w_pb_nxt + r_wr_cnt[addr_bw-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_pend   <= 1'b0;
            r_acc    <= 1'b0;
            r_len    <= '0;
            r_wb     <= '0;
            r_ab     <= '0;
            r_pb     <= '0;
            r_inst   <= IDLE_W;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_pend   <= w_pend_nxt;
            r_acc    <= w_acc_nxt;
            r_len    <= w_len_nxt;
            r_wb     <= w_wb_nxt;
            r_ab     <= w_ab_nxt;
            r_pb     <= w_pb_nxt;
            r_inst   <= w_inst_nxt;
            r_busy   <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf, r_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf  <= '0;
            r_stall <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_perf  <= '0;
            r_stall <= '0;
        end else begin
            if (r_busy && r_perf != '1)
                r_perf <= r_perf + 32'd1;
            if (r_state == S_DRAIN && !valid && r_stall != '1)
                r_stall <= r_stall + 32'd1;
        end
    end

    assign perf_cycles  = r_perf;
    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// Randomized self-checking bench for ws_inst_sequencer against a per-tile transaction model.
module tb_ws_inst_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] len = '0, w_base = '0, a_base = '0, p_base = '0;
    logic        acc_en = 1'b0;
    logic        valid = 1'b0;
    logic [33:0] inst;
    logic        busy, done;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles, stall_cycles;
`endif

    ws_inst_sequencer #(.row(ROW), .col(COL), .addr_bw(11), .inst_bw(34)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .w_base(w_base),
        .a_base(a_base), .p_base(p_base), .acc_en(acc_en), .valid(valid),
        .inst(inst), .busy(busy), .done(done)
`ifdef SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One tile: drive start, watch every cycle until done, then compare against the
    // address/strobe sets the tile rules imply.
    task automatic run_tile(input string tag, input int n, input logic [10:0] wb,
                            input logic [10:0] ab, input logic [10:0] pb,
                            input logic ac, input int vmode, input bit mid_start);
        logic [10:0] xq[$];
        logic [10:0] pq[$];
        logic [10:0] ex[$];
        logic [10:0] ep[$];
        logic [10:0] t;
        int nload = 0, nexec = 0, nl0w = 0, nl0r = 0, nrd = 0;
        int viol = 0, accbad = 0, donecnt = 0, donecyc = -1, nonidle = 0, nbusy = 0;
        int xm = 0, pm = 0, post_bad = 0;
        bit prev_rd = 0, prev_v = 0, busy0 = 0;

        @(negedge clk);
        start = 1'b1; len = n[10:0]; w_base = wb; a_base = ab; p_base = pb; acc_en = ac;
        valid = (vmode == 0);
        @(negedge clk);
        start = 1'b0;
        len = 11'($urandom); w_base = 11'($urandom); a_base = 11'($urandom);
        p_base = 11'($urandom); acc_en = 1'($urandom);
        for (int cyc = 0; cyc < 4000 && donecnt == 0; cyc++) begin
            if (cyc == 0) busy0 = busy;
            if (inst !== IDLE_W) nonidle++;
            if (busy) nbusy++;
            if (!inst[19]) begin
                xq.push_back(inst[17:7]);
                if (!inst[18]) viol++;
            end
            if (!inst[32]) begin
                pq.push_back(inst[30:20]);
                if (inst[31] || !prev_rd) viol++;
            end else if (!inst[31]) viol++;
            if (inst[6] && !prev_v) viol++;
            nrd   += int'(inst[6]);
            nload += int'(inst[0]);
            nexec += int'(inst[1]);
            nl0w  += int'(inst[2]);
            nl0r  += int'(inst[3]);
            if (busy && inst[33] !== ac) accbad++;
            if (done) begin
                donecnt++;
                donecyc = cyc;
                if (busy || inst !== IDLE_W) viol++;
            end else if (n > 0 && !busy) viol++;
            prev_rd = inst[6];
            case (vmode)
                0:       valid = 1'b1;
                1:       valid = ((cyc % 3) == 0);
                default: valid = 1'($urandom_range(0, 1));
            endcase
            prev_v = valid;
            if (mid_start && cyc == 20) begin
                start = 1'b1; len = 11'd9; w_base = 11'd500; a_base = 11'd600; p_base = 11'd700;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy || inst !== IDLE_W) post_bad++;
            @(negedge clk);
        end

        if (n > 0) begin
            for (int i = 0; i < ROW; i++) begin t = wb + 11'(i); ex.push_back(t); end
            for (int i = 0; i < n; i++)   begin t = ab + 11'(i); ex.push_back(t); end
            for (int i = 0; i < n; i++)   begin t = pb + 11'(i); ep.push_back(t); end
        end
        for (int i = 0; i < ex.size() && i < xq.size(); i++) if (xq[i] !== ex[i]) xm++;
        for (int i = 0; i < ep.size() && i < pq.size(); i++) if (pq[i] !== ep[i]) pm++;

        chk({tag, ".done_seen"}, 64'(donecnt), 64'd1);
        chk({tag, ".busy_first"}, 64'(busy0), 64'(n > 0));
        chk({tag, ".xmem_cnt"}, 64'(xq.size()), 64'(ex.size()));
        chk({tag, ".xmem_addr"}, 64'(xm), 64'd0);
        chk({tag, ".pmem_cnt"}, 64'(pq.size()), 64'(ep.size()));
        chk({tag, ".pmem_addr"}, 64'(pm), 64'd0);
        chk({tag, ".ofifo_rd"}, 64'(nrd), 64'(n));
        chk({tag, ".load"}, 64'(nload), 64'((n > 0) ? ROW + COL : 0));
        chk({tag, ".exec"}, 64'(nexec), 64'(n));
        chk({tag, ".l0_wr"}, 64'(nl0w), 64'((n > 0) ? ROW + n : 0));
        chk({tag, ".l0_rd"}, 64'(nl0r), 64'((n > 0) ? ROW + COL + n : 0));
        chk({tag, ".protocol"}, 64'(viol), 64'd0);
        chk({tag, ".acc"}, 64'(accbad), 64'd0);
        chk({tag, ".post_idle"}, 64'(post_bad), 64'd0);
        if (n == 0) begin
            chk({tag, ".done_cycle"}, 64'(donecyc), 64'd0);
            chk({tag, ".never_busy_word"}, 64'(nonidle), 64'd0);
        end
`ifdef SEQ_PERF_CNT_EN
        chk({tag, ".perf_cycles"}, 64'(perf_cycles), 64'(nbusy));
        if (vmode == 0) chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'd0);
`endif
    endtask

    task automatic reset_mid();
        int k;
        @(negedge clk);
        start = 1'b1; len = 11'd6; w_base = 11'd40; a_base = 11'd80; p_base = 11'd120; acc_en = 1'b1;
        @(negedge clk);
        start = 1'b0; valid = 1'b1;
        for (k = 0; k < 200 && !inst[1]; k++) @(negedge clk);
        chk("rst.exec_reached", 64'(inst[1]), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst.inst", 64'(inst), 64'(IDLE_W));
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.idle_after", 64'(inst), 64'(IDLE_W));
        chk("rst.busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int bad = 0;
        reset = 1'b0;
        #1;
        chk("reset.inst", 64'(inst), 64'(IDLE_W));
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst !== IDLE_W || busy || done) bad++;
        end
        chk("reset.hold20", 64'(bad), 64'd0);

        run_tile("basic",    4, 11'd0,    11'd16,   11'd100,  1'b0, 0, 1'b0);
        run_tile("toggle",   4, 11'd0,    11'd16,   11'd100,  1'b1, 1, 1'b0);
        run_tile("wrap",     4, 11'd2044, 11'd2046, 11'd2047, 1'b0, 0, 1'b0);
        run_tile("len0",     0, 11'd5,    11'd6,    11'd7,    1'b1, 0, 1'b0);
        run_tile("midstart", 4, 11'd10,   11'd30,   11'd200,  1'b1, 2, 1'b1);
        reset_mid();
        run_tile("post_rst", 5, 11'd300,  11'd400,  11'd900,  1'b1, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_tile($sformatf("rand%0d", r), int'($urandom_range(1, 12)),
                     11'($urandom), 11'($urandom), 11'($urandom),
                     1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
